// File: rtl/uart_echo_fifo_if.sv
// Handshake bundle between the UART receiver/transmitter and the buffered echo controller.
interface uart_echo_fifo_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] rbr;
    logic          rdrdy;
    logic          rdrst;
    logic [DW-1:0] tdin;
    logic          tbre;
    logic          wrn;

    // Controller side: consumes receive bytes and issues transmit strobes.
    modport master (
        input  rbr, rdrdy, tbre,
        output rdrst, tdin, wrn
    );

    // UART side: presents receive bytes and accepts transmit strobes.
    modport slave (
        output rbr, rdrdy, tbre,
        input  rdrst, tdin, wrn
    );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffered UART loopback: RX handshake FSM feeds a DEPTH-entry FIFO drained by a TX strobe FSM,
// with optional line buffering (hold until EOL or full) and a sticky overflow flag.
module uart_echo_fifo #(
    parameter int unsigned   DW  = 8,
    parameter int unsigned   AW  = 4,
    parameter logic [DW-1:0] EOL = DW'(8'h0D),
    parameter int unsigned   GAP = 1
) (
    input  logic             genclk,
    input  logic             RST,
    input  logic             line_mode,
    uart_echo_fifo_if.master uart,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {R_INIT, R_CLR, R_WAIT, R_ACK} rx_state_e;
    typedef enum logic [1:0] {T_IDLE, T_STROBE, T_GAP} tx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    tx_state_e     tx_state_q, tx_state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          drain_q, drain_d;
    logic [DW-1:0] tdin_q, tdin_d;
    logic          wrn_q, wrn_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic capture;
    logic push;
    logic pop;
    logic drain_eff;

    // RX handshake: one-cycle ack, then one blind cycle so the cleared rdrdy is not re-sampled.
    always_comb begin
        rx_state_d = rx_state_q;
        capture    = 1'b0;
        case (rx_state_q)
            R_INIT: rx_state_d = R_CLR;
            R_CLR:  rx_state_d = R_WAIT;
            R_WAIT: begin
                if (uart.rdrdy) begin
                    capture    = 1'b1;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK:  rx_state_d = R_CLR;
            default: rx_state_d = R_INIT;
        endcase
    end

    assign drain_eff = !line_mode || drain_q;

    always_comb begin
        tx_state_d = tx_state_q;
        pop        = 1'b0;
        wrn_d      = 1'b0;
        tdin_d     = tdin_q;
        gap_d      = gap_q;
        case (tx_state_q)
            T_IDLE: begin
                if (drain_eff && (count_q != '0) && !uart.tbre) begin
                    pop        = 1'b1;
                    tdin_d     = mem_q[rd_ptr_q];
                    wrn_d      = 1'b1;
                    tx_state_d = T_STROBE;
                end
            end
            T_STROBE: begin
                gap_d      = '0;
                tx_state_d = (GAP == 0) ? T_IDLE : T_GAP;
            end
            T_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    tx_state_d = T_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // A same-edge pop frees the head slot, so a full FIFO still accepts the captured byte.
    always_comb begin
        push     = capture && ((count_q < FULL) || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d   = ovf_q || (capture && !push);
        drain_d = drain_q;
        if ((push && (uart.rbr == EOL)) || (count_d == FULL)) begin
            drain_d = 1'b1;
        end else if (count_d == '0) begin
            drain_d = 1'b0;
        end
    end

    always_ff @(posedge genclk) begin
        if (RST) begin
            rx_state_q <= R_INIT;
            tx_state_q <= T_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drain_q    <= 1'b0;
            tdin_q     <= '0;
            wrn_q      <= 1'b0;
            gap_q      <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drain_q    <= drain_d;
            tdin_q     <= tdin_d;
            wrn_q      <= wrn_d;
            gap_q      <= gap_d;
        end
    end

    always_ff @(posedge genclk) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= uart.rbr;
        end
    end

    // rdrst is decoded from state but held low throughout reset.
    assign uart.rdrst = !RST && ((rx_state_q == R_INIT) || (rx_state_q == R_ACK));
    assign uart.tdin  = tdin_q;
    assign uart.wrn   = wrn_q;
    assign count      = count_q;
    assign ovf        = ovf_q;
    assign busy       = (count_q != '0) || (tx_state_q != T_IDLE);
endmodule
